// File: rtl/instruction_fetch_stage_pkg.sv
// Shared MIPS fetch definitions: NOP encoding, text-segment and reset-PC
// defaults, the next-PC select encoding and the branch displacement helper.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;

  // Source of the next fetch PC, in increasing priority order.
  typedef enum logic [1:0] {
    SEL_PC4    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JR     = 2'd3
  } pc_sel_e;

  // Sign-extended word offset converted to a byte displacement.
  function automatic logic signed [31:0] branch_disp(input logic signed [15:0] off);
    logic signed [31:0] disp;
    disp = {{14{off[15]}}, off, 2'b00};
    return disp;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Program-memory bus between the fetch stage and a combinational instruction
// memory.
//   imem_address     : byte address (pc - TEXT_BASE), driven by the fetch stage
//   imem_instruction : instruction word returned by the memory
interface instruction_fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] imem_address;
  logic [DATA_WIDTH-1:0] imem_instruction;

  modport master (output imem_address, input imem_instruction);
  modport slave  (input imem_address, output imem_instruction);
endinterface

// File: rtl/instruction_fetch_stage_pc_next_logic.sv
// Combinational next-PC selection for the fetch stage.
//   pc, id_pc_plus4, id_valid       : current fetch PC and IF/ID slot state
//   branch_taken/branch_offset      : conditional branch request from decode
//   jump/jump_index                 : j/jal request from decode
//   jump_register/jr_target         : jr/jalr request from decode
//   next_pc    : PC to load on the next unstalled or redirecting edge
//   redirect   : a redirect is being taken this cycle
//   misaligned : the taken redirect is a jr whose target is not word aligned
module pc_next_logic
  import instruction_fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] id_pc_plus4,
  input  logic                  id_valid,
  input  logic                  branch_taken,
  input  logic signed [15:0]    branch_offset,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  jump_register,
  input  logic [DATA_WIDTH-1:0] jr_target,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  redirect,
  output logic                  misaligned
);

  pc_sel_e               sel;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] branch_target;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] jr_aligned;

  assign pc_plus4      = pc + DATA_WIDTH'(4);
  assign branch_target = id_pc_plus4 + $unsigned(branch_disp(branch_offset));
  assign jump_target   = {id_pc_plus4[31:28], jump_index, 2'b00};
  assign jr_aligned    = {jr_target[31:2], 2'b00};

  // Requests from decode only count when the IF/ID slot holds a real
  // instruction; a bubble cannot be a branch or jump.
  always_comb begin
    sel = SEL_PC4;
    if (id_valid) begin
      if (jump_register)     sel = SEL_JR;
      else if (jump)         sel = SEL_JUMP;
      else if (branch_taken) sel = SEL_BRANCH;
    end
  end

  always_comb begin
    next_pc    = pc_plus4;
    redirect   = 1'b0;
    misaligned = 1'b0;
    unique case (sel)
      SEL_JR: begin
        next_pc    = jr_aligned;
        redirect   = 1'b1;
        misaligned = |jr_target[1:0];
      end
      SEL_JUMP: begin
        next_pc  = jump_target;
        redirect = 1'b1;
      end
      SEL_BRANCH: begin
        next_pc  = branch_target;
        redirect = 1'b1;
      end
      default: begin
        next_pc  = pc_plus4;
      end
    endcase
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: program counter plus the IF/ID register.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   stall               : hold PC and IF/ID
//   branch_taken/offset : branch redirect from decode (16-bit word offset)
//   jump/jump_index     : j/jal redirect from decode
//   jump_register/jr_target : jr/jalr redirect from decode
//   imem                : program-memory bus (address out, instruction in)
//   pc                  : current fetch PC
//   id_instruction      : IF/ID instruction word
//   id_pc_plus4         : IF/ID PC+4 of that instruction
//   id_valid            : IF/ID holds a real instruction
//   misaligned_jr       : one-cycle pulse after a jr to a non-word-aligned target
//   fetch_out_of_range  : current fetch address lies beyond the program memory
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter logic [31:0] TEXT_BASE    = TEXT_BASE_DEFAULT,
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic signed [15:0]         branch_offset,
  input  logic                       jump,
  input  logic [25:0]                jump_index,
  input  logic                       jump_register,
  input  logic [DATA_WIDTH-1:0]      jr_target,
  instruction_fetch_stage_if.master  imem,
  output logic [DATA_WIDTH-1:0]      pc,
  output logic [DATA_WIDTH-1:0]      id_instruction,
  output logic [DATA_WIDTH-1:0]      id_pc_plus4,
  output logic                       id_valid,
  output logic                       misaligned_jr,
  output logic                       fetch_out_of_range
);

  localparam logic [DATA_WIDTH-1:0] IMEM_BYTES = DATA_WIDTH'(MEMORY_DEPTH * 4);

  logic [DATA_WIDTH-1:0] pc_p0;
  logic [DATA_WIDTH-1:0] id_instruction_p1;
  logic [DATA_WIDTH-1:0] id_pc_plus4_p1;
  logic                  vld_p1;
  logic                  misaligned_p1;

  logic [DATA_WIDTH-1:0] next_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  redirect;
  logic                  misaligned;

  pc_next_logic #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pc_next (
    .pc            (pc_p0),
    .id_pc_plus4   (id_pc_plus4_p1),
    .id_valid      (vld_p1),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_register (jump_register),
    .jr_target     (jr_target),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .misaligned    (misaligned)
  );

  assign pc_plus4           = pc_p0 + DATA_WIDTH'(4);
  assign imem.imem_address  = pc_p0 - TEXT_BASE;
  // Informational only: fetch still proceeds and latches whatever memory returns.
  assign fetch_out_of_range = (imem.imem_address >= IMEM_BYTES);

  // Fetch stage (p0): program counter. A redirect wins over stall so that a
  // resolved branch is never lost while the hazard unit is holding the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (redirect) begin
      pc_p0 <= next_pc;
    end else if (!stall) begin
      pc_p0 <= next_pc;
    end
  end

  // IF/ID boundary (p1): captured instruction, its PC+4, valid and the jr
  // alignment pulse. A redirect flushes the slot to a NOP bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instruction_p1 <= NOP_INSTR;
      id_pc_plus4_p1    <= '0;
      vld_p1            <= 1'b0;
      misaligned_p1     <= 1'b0;
    end else if (redirect) begin
      id_instruction_p1 <= NOP_INSTR;
      id_pc_plus4_p1    <= '0;
      vld_p1            <= 1'b0;
      misaligned_p1     <= misaligned;
    end else if (stall) begin
      misaligned_p1     <= 1'b0;
    end else begin
      id_instruction_p1 <= imem.imem_instruction;
      id_pc_plus4_p1    <= pc_plus4;
      vld_p1            <= 1'b1;
      misaligned_p1     <= 1'b0;
    end
  end

  assign pc             = pc_p0;
  assign id_instruction = id_instruction_p1;
  assign id_pc_plus4    = id_pc_plus4_p1;
  assign id_valid       = vld_p1;
  assign misaligned_jr  = misaligned_p1;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall;
  logic               branch_taken;
  logic signed [15:0] branch_offset;
  logic               jump;
  logic [25:0]        jump_index;
  logic               jump_register;
  logic [31:0]        jr_target;
  logic [31:0]        pc;
  logic [31:0]        id_instruction;
  logic [31:0]        id_pc_plus4;
  logic               id_valid;
  logic               misaligned_jr;
  logic               fetch_out_of_range;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BAD_WORD = 32'hBAD0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  logic [31:0] mem [32];

  instruction_fetch_stage_if #(.DATA_WIDTH(32)) imem_bus ();

  // Combinational program memory; out-of-range reads return a marker word.
  assign imem_bus.imem_instruction = (imem_bus.imem_address < 32'd128) ?
                                     mem[imem_bus.imem_address[6:2]] : BAD_WORD;

  instruction_fetch_stage #(
    .RESET_PC     (32'h0040_0000),
    .TEXT_BASE    (32'h0040_0000),
    .MEMORY_DEPTH (32),
    .DATA_WIDTH   (32)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .branch_taken       (branch_taken),
    .branch_offset      (branch_offset),
    .jump               (jump),
    .jump_index         (jump_index),
    .jump_register      (jump_register),
    .jr_target          (jr_target),
    .imem               (imem_bus.master),
    .pc                 (pc),
    .id_instruction     (id_instruction),
    .id_pc_plus4        (id_pc_plus4),
    .id_valid           (id_valid),
    .misaligned_jr      (misaligned_jr),
    .fetch_out_of_range (fetch_out_of_range)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic exp_t mk(input logic [31:0] p, input logic [31:0] ins,
                              input logic [31:0] p4, input logic v, input logic m);
    exp_t e;
    e.pc = p; e.instr = ins; e.pc4 = p4; e.valid = v; e.mis = m;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_state(input string tag, input exp_t e);
    chk({tag, ".pc"},    pc,                   e.pc);
    chk({tag, ".instr"}, id_instruction,       e.instr);
    chk({tag, ".pc4"},   id_pc_plus4,          e.pc4);
    chk({tag, ".valid"}, {31'd0, id_valid},    {31'd0, e.valid});
    chk({tag, ".mis"},   {31'd0, misaligned_jr}, {31'd0, e.mis});
  endtask

  // Push the expected post-edge state, advance one edge, then pop and compare.
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      got = sb.pop_front();
      compare_state(tag, got);
    end
  endtask

  task automatic clear_redirects();
    branch_taken  = 1'b0;
    branch_offset = 16'sd0;
    jump          = 1'b0;
    jump_index    = 26'd0;
    jump_register = 1'b0;
    jr_target     = 32'd0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = w(i);
    reset = 1'b1;
    stall = 1'b0;
    clear_redirects();

    // Reset values
    #1;
    compare_state("reset", mk(32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0));
    chk("reset.addr", imem_bus.imem_address, 32'h0);
    chk("reset.oor",  {31'd0, fetch_out_of_range}, 32'd0);
    #1 reset = 1'b0;

    // Clean fetch
    step("fetch1", mk(32'h0040_0004, w(0), 32'h0040_0004, 1'b1, 1'b0));
    chk("fetch1.addr", imem_bus.imem_address, 32'h4);
    step("fetch2", mk(32'h0040_0008, w(1), 32'h0040_0008, 1'b1, 1'b0));
    chk("fetch2.addr", imem_bus.imem_address, 32'h8);

    // Stall two cycles at pc=0x00400008
    stall = 1'b1;
    step("stall1", mk(32'h0040_0008, w(1), 32'h0040_0008, 1'b1, 1'b0));
    step("stall2", mk(32'h0040_0008, w(1), 32'h0040_0008, 1'b1, 1'b0));
    stall = 1'b0;
    step("resume", mk(32'h0040_000C, w(2), 32'h0040_000C, 1'b1, 1'b0));
    chk("resume.addr", imem_bus.imem_address, 32'hC);
    step("fetch4", mk(32'h0040_0010, w(3), 32'h0040_0010, 1'b1, 1'b0));

    // Backward branch from id_pc_plus4=0x00400010 by -2 words
    branch_taken  = 1'b1;
    branch_offset = 16'shFFFE;
    step("branch", mk(32'h0040_0008, 32'h0, 32'h0, 1'b0, 1'b0));
    // Still asserted, but the slot is a bubble
    step("branch_bubble", mk(32'h0040_000C, w(2), 32'h0040_000C, 1'b1, 1'b0));
    clear_redirects();

    // jr beats jump and stall; misaligned target
    jump          = 1'b1;
    jump_index    = 26'h0100040;
    jump_register = 1'b1;
    jr_target     = 32'h0040_0023;
    stall         = 1'b1;
    step("jr_prio", mk(32'h0040_0020, 32'h0, 32'h0, 1'b0, 1'b1));
    clear_redirects();
    stall = 1'b0;
    step("after_jr", mk(32'h0040_0024, w(8), 32'h0040_0024, 1'b1, 1'b0));

    // PC wrap
    jump_register = 1'b1;
    jr_target     = 32'hFFFF_FFFC;
    step("jr_top", mk(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0));
    chk("jr_top.addr", imem_bus.imem_address, 32'hFFBF_FFFC);
    chk("jr_top.oor",  {31'd0, fetch_out_of_range}, 32'd1);
    clear_redirects();
    step("wrap", mk(32'h0000_0000, BAD_WORD, 32'h0, 1'b1, 1'b0));
    chk("wrap.addr", imem_bus.imem_address, 32'hFFC0_0000);

    // Range boundary: 0x80 is first byte beyond 32 words
    jump       = 1'b1;
    jump_index = 26'h0100020;
    step("jump80", mk(32'h0040_0080, 32'h0, 32'h0, 1'b0, 1'b0));
    chk("jump80.addr", imem_bus.imem_address, 32'h80);
    chk("jump80.oor",  {31'd0, fetch_out_of_range}, 32'd1);
    clear_redirects();
    step("fetch84", mk(32'h0040_0084, BAD_WORD, 32'h0040_0084, 1'b1, 1'b0));
    branch_taken  = 1'b1;
    branch_offset = 16'shFFFE;
    step("branch7c", mk(32'h0040_007C, 32'h0, 32'h0, 1'b0, 1'b0));
    chk("branch7c.oor", {31'd0, fetch_out_of_range}, 32'd0);
    clear_redirects();
    step("fetch7c", mk(32'h0040_0080, w(31), 32'h0040_0080, 1'b1, 1'b0));

    // Async reset mid-cycle with a jr pending
    jump_register = 1'b1;
    jr_target     = 32'h0040_0041;
    #2 reset = 1'b1;
    #1;
    compare_state("async_rst", mk(32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0));
    clear_redirects();
    #1 reset = 1'b0;
    step("post_rst", mk(32'h0040_0004, w(0), 32'h0040_0004, 1'b1, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
